// File: rtl/obi_mem_arbiter.sv
// Two-port OBI arbiter (instruction/data) in front of one single-port SRAM.
// Round-robin on conflicts, fixed one-cycle response latency.
module obi_mem_arbiter #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         i_req_i,
  output logic                         i_gnt_o,
  output logic                         i_rvalid_o,
  input  logic [31:0]                  i_addr_i,
  output logic [31:0]                  i_rdata_o,
  input  logic                         d_req_i,
  output logic                         d_gnt_o,
  output logic                         d_rvalid_o,
  input  logic [31:0]                  d_addr_i,
  input  logic                         d_we_i,
  input  logic [3:0]                   d_be_i,
  input  logic [31:0]                  d_wdata_i,
  output logic [31:0]                  d_rdata_o,
  output logic                         d_err_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  output logic [3:0]                   mem_be_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic [31:0]                  conflict_cnt_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic        rr_d_q;
  logic        rsp_i_q;
  logic        rsp_d_q;
  logic        rsp_oor_q;
  logic        rsp_we_q;
  logic [31:0] cnt_q;
  logic [31:0] i_off;
  logic [31:0] d_off;
  logic        i_in;
  logic        d_in;
  logic        conflict;
  logic        i_gnt;
  logic        d_gnt;

  // Below-base addresses wrap to huge offsets, so one test covers both ends.
  assign i_off = i_addr_i - BASE_ADDR;
  assign d_off = d_addr_i - BASE_ADDR;
  assign i_in  = (i_off >> (AW + 2)) == '0;
  assign d_in  = (d_off >> (AW + 2)) == '0;

  assign conflict = i_req_i & d_req_i & ~rst_i;
  assign d_gnt = ~rst_i & d_req_i & (~i_req_i | rr_d_q);
  assign i_gnt = ~rst_i & i_req_i & (~d_req_i | ~rr_d_q);

  assign i_gnt_o = i_gnt;
  assign d_gnt_o = d_gnt;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      d_gnt: begin
        mem_req_o   = d_in;
        mem_we_o    = d_in & d_we_i;
        mem_addr_o  = d_off[AW+1:2];
        mem_be_o    = d_be_i;
        mem_wdata_o = d_wdata_i;
      end
      i_gnt: begin
        mem_req_o  = i_in;
        mem_addr_o = i_off[AW+1:2];
        mem_be_o   = 4'hF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_d_q    <= 1'b1;
      rsp_i_q   <= 1'b0;
      rsp_d_q   <= 1'b0;
      rsp_oor_q <= 1'b0;
      rsp_we_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rsp_i_q   <= i_gnt;
      rsp_d_q   <= d_gnt;
      rsp_oor_q <= d_gnt ? ~d_in : ~i_in;
      rsp_we_q  <= d_gnt & d_we_i;
      if (conflict) begin
        rr_d_q <= ~rr_d_q;
        if (cnt_q != '1)
          cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign i_rvalid_o = rsp_i_q;
  assign d_rvalid_o = rsp_d_q;
  assign d_err_o    = rsp_d_q & rsp_oor_q;

  // Writes and out-of-range accesses answer with zero data.
  assign i_rdata_o = (rsp_i_q & ~rsp_oor_q) ? mem_rdata_i : '0;
  assign d_rdata_o = (rsp_d_q & ~rsp_oor_q & ~rsp_we_q)
                   ? mem_rdata_i : '0;

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Scoreboard bench for obi_mem_arbiter: directed stimulus pushes expected
// responses; a negedge monitor pops and compares each rvalid.
module tb_obi_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_req_i;
  logic        i_gnt_o;
  logic        i_rvalid_o;
  logic [31:0] i_addr_i;
  logic [31:0] i_rdata_o;
  logic        d_req_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_addr_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [13:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic [31:0] conflict_cnt_o;

  typedef struct {
    bit          port;
    logic [31:0] data;
    logic        err;
    int          due;
  } rsp_t;

  rsp_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  obi_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_addr_i(i_addr_i),
    .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_addr_i(d_addr_i),
    .d_we_i(d_we_i), .d_be_i(d_be_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o),
    .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // SRAM stand-in: read data is a per-cycle signature.
  assign mem_rdata_i = 32'hC0DE_0000 ^ 32'(cyc);

  function automatic logic [31:0] rd(input int c);
    return 32'hC0DE_0000 ^ 32'(c);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit p, input logic [31:0] d, input logic e);
    rsp_t r;
    r.port = p;
    r.data = d;
    r.err  = e;
    r.due  = cyc + 1;
    q.push_back(r);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic we,
                       input logic [3:0] be, input logic [31:0] da,
                       input logic [31:0] wd);
    @(posedge clk_i);
    #1;
    i_req_i = ir;  i_addr_i = ia;
    d_req_i = dr;  d_we_i   = we;
    d_be_i  = be;  d_addr_i = da;
    d_wdata_i = wd;
    @(negedge clk_i);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic dread(input logic [31:0] a);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, a, 32'h0);
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (i_rvalid_o || d_rvalid_o) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_rvalid: got i=%b d=%b want none (cycle %0d)",
                 i_rvalid_o, d_rvalid_o, cyc);
      end else begin
        rsp_t e;
        e = q.pop_front();
        chk("rsp_both_valid", {31'b0, i_rvalid_o & d_rvalid_o}, 32'd0);
        chk("rsp_port", {31'b0, d_rvalid_o}, {31'b0, e.port});
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
        chk("rsp_rdata", e.port ? d_rdata_o : i_rdata_o, e.data);
        chk("rsp_err", {31'b0, d_err_o}, {31'b0, e.err});
      end
    end else begin
      chk("idle_i_rdata", i_rdata_o, 32'h0);
      chk("idle_d_rdata", d_rdata_o, 32'h0);
      chk("idle_d_err", {31'b0, d_err_o}, 32'd0);
    end
  end

  initial begin
    rst_i = 1'b1;
    i_req_i = 0; i_addr_i = 0; d_req_i = 0; d_we_i = 0;
    d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_i_gnt", {31'b0, i_gnt_o}, 32'd0);
    chk("rst_d_gnt", {31'b0, d_gnt_o}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_cnt", conflict_cnt_o, 32'd0);

    // First grant on the first edge after reset release.
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    i_req_i = 1'b1;
    i_addr_i = 32'h0002_0010;
    @(negedge clk_i);
    chk("s1_i_gnt", {31'b0, i_gnt_o}, 32'd1);
    chk("s1_d_gnt", {31'b0, d_gnt_o}, 32'd0);
    chk("s1_mem_req", {31'b0, mem_req_o}, 32'd1);
    chk("s1_mem_addr", {18'b0, mem_addr_o}, 32'd4);
    chk("s1_mem_we", {31'b0, mem_we_o}, 32'd0);
    chk("s1_mem_be", {28'b0, mem_be_o}, 32'hF);
    push(1'b0, rd(cyc + 1), 1'b0);

    // Four conflict cycles: D, I, D, I.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h0002_0020, 1'b1, 1'b0, 4'hF,
            32'h0002_0040, 32'h0);
      if (k % 2 == 0) begin
        chk("s2_d_gnt", {31'b0, d_gnt_o}, 32'd1);
        chk("s2_i_gnt", {31'b0, i_gnt_o}, 32'd0);
        chk("s2_addr_d", {18'b0, mem_addr_o}, 32'h10);
        push(1'b1, rd(cyc + 1), 1'b0);
      end else begin
        chk("s2_i_gnt", {31'b0, i_gnt_o}, 32'd1);
        chk("s2_d_gnt", {31'b0, d_gnt_o}, 32'd0);
        chk("s2_addr_i", {18'b0, mem_addr_o}, 32'h8);
        push(1'b0, rd(cyc + 1), 1'b0);
      end
    end
    idle();
    chk("s2_cnt", conflict_cnt_o, 32'd4);

    // Partial write.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101,
          32'h0002_0008, 32'hA5A5_A5A5);
    chk("s3_d_gnt", {31'b0, d_gnt_o}, 32'd1);
    chk("s3_mem_req", {31'b0, mem_req_o}, 32'd1);
    chk("s3_mem_we", {31'b0, mem_we_o}, 32'd1);
    chk("s3_mem_addr", {18'b0, mem_addr_o}, 32'd2);
    chk("s3_mem_be", {28'b0, mem_be_o}, 32'h5);
    chk("s3_wdata", mem_wdata_o, 32'hA5A5_A5A5);
    push(1'b1, 32'h0, 1'b0);

    // Out-of-range data reads: far away, just below, just past the end.
    dread(32'h1000_0000);
    chk("s4_d_gnt", {31'b0, d_gnt_o}, 32'd1);
    chk("s4_mem_req", {31'b0, mem_req_o}, 32'd0);
    push(1'b1, 32'h0, 1'b1);
    dread(32'h0001_FFFC);
    chk("s4_below_req", {31'b0, mem_req_o}, 32'd0);
    push(1'b1, 32'h0, 1'b1);
    dread(32'h0003_0000);
    chk("s4_above_req", {31'b0, mem_req_o}, 32'd0);
    push(1'b1, 32'h0, 1'b1);

    // Last valid word, and low address bits ignored.
    dread(32'h0002_FFFC);
    chk("s4_top_req", {31'b0, mem_req_o}, 32'd1);
    chk("s4_top_addr", {18'b0, mem_addr_o}, 32'h3FFF);
    push(1'b1, rd(cyc + 1), 1'b0);
    dread(32'h0002_0013);
    chk("s4_unal_addr", {18'b0, mem_addr_o}, 32'd4);
    push(1'b1, rd(cyc + 1), 1'b0);

    // Out-of-range instruction fetch.
    drive(1'b1, 32'h0000_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("s5_i_gnt", {31'b0, i_gnt_o}, 32'd1);
    chk("s5_mem_req", {31'b0, mem_req_o}, 32'd0);
    push(1'b0, 32'h0, 1'b0);

    // Eight back-to-back data reads.
    for (int k = 0; k < 8; k++) begin
      dread(32'h0002_0100 + 32'(4 * k));
      chk("s6_d_gnt", {31'b0, d_gnt_o}, 32'd1);
      chk("s6_addr", {18'b0, mem_addr_o}, 32'h40 + 32'(k));
      push(1'b1, rd(cyc + 1), 1'b0);
    end
    idle();

    // Reset hits while a response is pending; it must be dropped.
    dread(32'h0002_0000);
    chk("s7_d_gnt", {31'b0, d_gnt_o}, 32'd1);
    #1;
    rst_i = 1'b1;
    i_req_i = 1'b1;
    #1;
    chk("s7_gnt_off", {30'b0, i_gnt_o, d_gnt_o}, 32'd0);
    chk("s7_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("s7_cnt", conflict_cnt_o, 32'd0);
    repeat (2) @(negedge clk_i);
    chk("s7_rvalid", {30'b0, i_rvalid_o, d_rvalid_o}, 32'd0);
    chk("s7_rdata", i_rdata_o | d_rdata_o, 32'h0);
    chk("s7_cnt_hold", conflict_cnt_o, 32'd0);

    // Pointer back to data-first after reset.
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    i_addr_i = 32'h0002_0004;
    d_addr_i = 32'h0002_000C;
    @(negedge clk_i);
    chk("s8_d_first", {30'b0, i_gnt_o, d_gnt_o}, 32'b01);
    chk("s8_addr", {18'b0, mem_addr_o}, 32'd3);
    push(1'b1, rd(cyc + 1), 1'b0);
    drive(1'b1, 32'h0002_0004, 1'b1, 1'b0, 4'hF,
          32'h0002_000C, 32'h0);
    chk("s8_i_next", {30'b0, i_gnt_o, d_gnt_o}, 32'b10);
    push(1'b0, rd(cyc + 1), 1'b0);
    idle();
    chk("s8_cnt", conflict_cnt_o, 32'd2);
    repeat (3) idle();

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obi_mem_arbiter.md
OBI_MEM_ARBITER -- requirements
Module: obi_mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 16384, SHALL give the memory depth in 32-bit words (power of two, ≥2).
REQ-002 Parameter BASE_ADDR, default 32'h0002_0000, SHALL give the byte address of memory word 0 (aligned to 4*MEM_WORDS).
REQ-003 Ports (name direction width meaning); one clock, reset asynchronous and active-high:
- clk_i in 1: clock.
- rst_i in 1: asynchronous active-high reset.
- i_req_i in 1: instruction-port request.
- i_gnt_o out 1: instruction-port grant.
- i_rvalid_o out 1: instruction-port response valid.
- i_addr_i in 32: instruction byte address.
- i_rdata_o out 32: instruction read data.
- d_req_i in 1: data-port request.
- d_gnt_o out 1: data-port grant.
- d_rvalid_o out 1: data-port response valid.
- d_addr_i in 32: data byte address.
- d_we_i in 1: data write enable.
- d_be_i in 4: data byte enables.
- d_wdata_i in 32: data write data.
- d_rdata_o out 32: data read data.
- d_err_o out 1: data response error.
- mem_req_o out 1: SRAM access.
- mem_we_o out 1: SRAM write.
- mem_addr_o out $clog2(MEM_WORDS): SRAM word address.
- mem_be_o out 4: SRAM byte enables.
- mem_wdata_o out 32: SRAM write data.
- mem_rdata_i in 32: SRAM read data, valid the cycle after mem_req_o.
- conflict_cnt_o out 32: count of cycles with simultaneous requests.

Function
REQ-004 Arbitration SHALL be combinational within the request cycle; at most one of i_gnt_o/d_gnt_o SHALL be high per cycle.
REQ-005 A lone requester SHALL be granted in the same cycle; gnt SHALL never be high without its req.
REQ-006 On simultaneous i_req_i and d_req_i, the port that lost the previous conflict SHALL be granted (round-robin).
REQ-007 The round-robin pointer SHALL change only on conflict cycles; after reset the data port SHALL win the first conflict.
REQ-008 A grant SHALL drive mem_req_o=1 the same cycle with the granted port's address, be, we and wdata.
REQ-009 Instruction grants SHALL drive mem_we_o=0 and mem_be_o=4'hF.
REQ-010 mem_addr_o SHALL equal (addr − BASE_ADDR)>>2, truncated to $clog2(MEM_WORDS) bits.
REQ-011 A data access with addr outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) SHALL be granted with mem_req_o=0.
REQ-012 Such an out-of-range access SHALL raise d_err_o with d_rvalid_o and return d_rdata_o=0.
REQ-013 An out-of-range instruction access SHALL be granted and answered with i_rdata_o=0 and mem_req_o=0.
REQ-014 Every grant SHALL produce exactly one rvalid on the same port, exactly one cycle later (fixed latency 1).
REQ-015 The response SHALL be routed by a registered port tag and out-of-range flag.
REQ-016 Writes SHALL also return rvalid, with rdata=0.
REQ-017 A grant and an rvalid MAY coincide on either port; sustained throughput SHALL be one access per cycle.
REQ-018 rdata outputs SHALL be 0 whenever the corresponding rvalid is low.
REQ-019 conflict_cnt_o SHALL increment on each simultaneous-request cycle and saturate at 32'hFFFF_FFFF.
REQ-020 Addresses SHALL be word-aligned; bits [1:0] SHALL be ignored.

Reset
REQ-021 rst_i SHALL immediately force low all gnt, rvalid, d_err_o and mem_req_o; set conflict_cnt_o=0; and set the round-robin pointer to data-first.
REQ-022 A response pending when rst_i asserts SHALL be discarded and never delivered.
REQ-023 The first grant SHALL be possible in the first clock edge after rst_i deasserts.

Verification
REQ-024 Bench SHALL cover these scenarios:
- Reset then i_req_i=1, i_addr_i=0x00020010 -> i_gnt_o same cycle, mem_addr_o=4; next cycle i_rvalid_o=1, i_rdata_o=mem_rdata_i.
- Both ports request for 4 cycles -> grants D,I,D,I; conflict_cnt_o=4; each rvalid one cycle after its grant.
- d_we_i=1, d_be_i=4'b0101, d_addr_i=0x00020008, d_wdata_i=0xA5A5A5A5 -> mem_we_o=1, mem_addr_o=2, mem_be_o=0101; next cycle d_rvalid_o=1, d_rdata_o=0.
- d_addr_i=0x10000000 read -> d_gnt_o=1, mem_req_o=0; next cycle d_rvalid_o=1, d_err_o=1, d_rdata_o=0.
- rst_i asserted the cycle after a grant -> no rvalid ever issued; outputs 0; conflict_cnt_o=0.
- Back-to-back data reads on 8 consecutive cycles -> 8 grants and 8 rvalids, contiguous, each one cycle later.
